// File: rtl/updown_counter_bcd.sv
// BCD up/down counter core: run/stop state machine, up/down mode flag,
// prescaler and an N-digit cascaded BCD counter with a programmable wrap limit.
module updown_counter_bcd #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned MAX_COUNT = 9999
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_mode,
  input  logic                    btn_run_stop,
  input  logic                    btn_clear,
  output logic [1:0]              led_mode,
  output logic [1:0]              led_run_stop,
  output logic [4*N_DIGITS-1:0]   count_bcd,
  output logic                    wrap
);

  localparam int unsigned CW = 4 * N_DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Decimal constant to packed BCD, evaluated at elaboration only.
  function automatic logic [CW-1:0] to_bcd(input int unsigned value);
    logic [CW-1:0] r;
    int unsigned   v;
    r = '0;
    v = value;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic [1:0]      led_run_stop_d;
  logic            mode_down;
  logic [PW-1:0]   presc;
  logic            step_c;
  logic [CW-1:0]   count_inc;
  logic [CW-1:0]   count_dec;
  logic            carry;
  logic            borrow;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_STOP;
    else       state <= state_next;
  end

  // Next-state: clear beats the run/stop toggle
  always_comb begin
    state_next = state;
    if (btn_clear)
      state_next = ST_STOP;
    else if (btn_run_stop)
      state_next = (state == ST_RUN) ? ST_STOP : ST_RUN;
  end

  // LED decode of the upcoming state, registered below
  always_comb begin
    led_run_stop_d = 2'b01;
    if (state_next == ST_RUN) led_run_stop_d = 2'b10;
  end

  assign step_c = (state == ST_RUN) && (presc == PRESC_LAST);

  // Ripple +1 / -1 across BCD digits
  always_comb begin
    count_inc = count_bcd;
    count_dec = count_bcd;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (count_bcd[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_bcd[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_down    <= 1'b0;
      presc        <= '0;
      count_bcd    <= '0;
      wrap         <= 1'b0;
      led_mode     <= 2'b01;
      led_run_stop <= 2'b01;
    end else begin
      wrap         <= 1'b0;
      led_run_stop <= led_run_stop_d;
      if (btn_mode) begin
        mode_down <= ~mode_down;
        led_mode  <= mode_down ? 2'b01 : 2'b10;
      end
      if (btn_clear) begin
        presc     <= '0;
        count_bcd <= '0;
      end else begin
        if (state == ST_RUN)
          presc <= step_c ? '0 : presc + PW'(1);
        // The step uses the mode as registered before any btn_mode this cycle
        if (step_c) begin
          if (!mode_down) begin
            if (count_bcd == MAX_BCD) begin
              count_bcd <= '0;
              wrap      <= 1'b1;
            end else begin
              count_bcd <= count_inc;
            end
          end else begin
            if (count_bcd == '0) begin
              count_bcd <= MAX_BCD;
              wrap      <= 1'b1;
            end else begin
              count_bcd <= count_dec;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_bcd.sv
// Directed bench for updown_counter_bcd with N_DIGITS=2, TICK_DIV=4, MAX_COUNT=59.
module tb_updown_counter_bcd;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_run_stop;
  logic       btn_clear;
  logic [1:0] led_mode;
  logic [1:0] led_run_stop;
  logic [7:0] count_bcd;
  logic       wrap;

  int n_checks = 0;
  int n_errors = 0;

  updown_counter_bcd #(
    .N_DIGITS (2),
    .TICK_DIV (4),
    .MAX_COUNT(59)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_run_stop(btn_run_stop),
    .btn_clear   (btn_clear),
    .led_mode    (led_mode),
    .led_run_stop(led_run_stop),
    .count_bcd   (count_bcd),
    .wrap        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Advance one edge and settle; inputs are changed only after this returns
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++;
    if (count_bcd !== 8'h00) begin n_errors++; $display("FAIL reset_count got %h exp 00", count_bcd); end
    n_checks++;
    if (led_mode !== 2'b01) begin n_errors++; $display("FAIL reset_led_mode got %b exp 01", led_mode); end
    n_checks++;
    if (led_run_stop !== 2'b01) begin n_errors++; $display("FAIL reset_led_run got %b exp 01", led_run_stop); end
    n_checks++;
    if (wrap !== 1'b0) begin n_errors++; $display("FAIL reset_wrap got %b exp 0", wrap); end
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp;
    btn_run_stop = 1'b1; tick(); btn_run_stop = 1'b0;
    n_checks++;
    if (led_run_stop !== 2'b10) begin n_errors++; $display("FAIL run_led got %b exp 10", led_run_stop); end
    for (int s = 1; s <= 60; s++) begin
      repeat (3) begin
        tick();
        n_checks++;
        if (count_bcd !== bcd(s - 1) || wrap !== 1'b0) begin
          n_errors++;
          $display("FAIL up_hold step %0d got %h/%b exp %h/0", s, count_bcd, wrap, bcd(s - 1));
        end
      end
      tick();
      exp = (s == 60) ? 8'h00 : bcd(s);
      n_checks++;
      if (count_bcd !== exp || wrap !== (s == 60)) begin
        n_errors++;
        $display("FAIL up_step %0d got %h/%b exp %h/%b", s, count_bcd, wrap, exp, (s == 60));
      end
    end
    tick();
    n_checks++;
    if (wrap !== 1'b0 || count_bcd !== 8'h00) begin
      n_errors++;
      $display("FAIL up_wrap_one_cycle got %h/%b exp 00/0", count_bcd, wrap);
    end
  endtask

  task automatic test_down_borrow();
    logic [7:0] exp;
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    btn_run_stop = 1'b1; tick(); btn_run_stop = 1'b0;
    repeat (40) tick();
    n_checks++;
    if (count_bcd !== 8'h10) begin n_errors++; $display("FAIL down_load got %h exp 10", count_bcd); end
    btn_mode = 1'b1; tick(); btn_mode = 1'b0;
    n_checks++;
    if (led_mode !== 2'b10) begin n_errors++; $display("FAIL down_led_mode got %b exp 10", led_mode); end
    for (int s = 1; s <= 11; s++) begin
      repeat ((s == 1) ? 2 : 3) begin
        tick();
        n_checks++;
        if (count_bcd[3:0] > 4'd9 || count_bcd[7:4] > 4'd9) begin
          n_errors++;
          $display("FAIL down_digit_range got %h", count_bcd);
        end
      end
      tick();
      exp = (s == 11) ? 8'h59 : bcd(10 - s);
      n_checks++;
      if (count_bcd !== exp || wrap !== (s == 11)) begin
        n_errors++;
        $display("FAIL down_step %0d got %h/%b exp %h/%b", s, count_bcd, wrap, exp, (s == 11));
      end
    end
  endtask

  task automatic test_stop_resume();
    tick();
    btn_run_stop = 1'b1; tick(); btn_run_stop = 1'b0;
    n_checks++;
    if (led_run_stop !== 2'b01) begin n_errors++; $display("FAIL stop_led got %b exp 01", led_run_stop); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (count_bcd !== 8'h59) begin n_errors++; $display("FAIL stop_frozen cyc %0d got %h exp 59", i, count_bcd); end
    end
    btn_run_stop = 1'b1; tick(); btn_run_stop = 1'b0;
    n_checks++;
    if (led_run_stop !== 2'b10) begin n_errors++; $display("FAIL resume_led got %b exp 10", led_run_stop); end
    tick();
    n_checks++;
    if (count_bcd !== 8'h59) begin n_errors++; $display("FAIL resume_early got %h exp 59", count_bcd); end
    tick();
    n_checks++;
    if (count_bcd !== 8'h58) begin n_errors++; $display("FAIL resume_step got %h exp 58", count_bcd); end
  endtask

  task automatic test_clear_step();
    repeat (3) tick();
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    n_checks++;
    if (count_bcd !== 8'h00 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_step got %h/%b exp 00/0", count_bcd, wrap);
    end
    n_checks++;
    if (led_run_stop !== 2'b01) begin n_errors++; $display("FAIL clear_state got %b exp 01", led_run_stop); end
    n_checks++;
    if (led_mode !== 2'b10) begin n_errors++; $display("FAIL clear_mode_kept got %b exp 10", led_mode); end
    repeat (5) tick();
    n_checks++;
    if (count_bcd !== 8'h00) begin n_errors++; $display("FAIL clear_frozen got %h exp 00", count_bcd); end
  endtask

  task automatic test_mode_step();
    btn_mode = 1'b1; tick(); btn_mode = 1'b0;
    btn_run_stop = 1'b1; tick(); btn_run_stop = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (count_bcd !== 8'h05) begin n_errors++; $display("FAIL mode_load got %h exp 05", count_bcd); end
    repeat (3) tick();
    btn_mode = 1'b1; tick(); btn_mode = 1'b0;
    n_checks++;
    if (count_bcd !== 8'h06) begin n_errors++; $display("FAIL mode_step_old got %h exp 06", count_bcd); end
    n_checks++;
    if (led_mode !== 2'b10) begin n_errors++; $display("FAIL mode_step_led got %b exp 10", led_mode); end
    repeat (4) tick();
    n_checks++;
    if (count_bcd !== 8'h05) begin n_errors++; $display("FAIL mode_step_new got %h exp 05", count_bcd); end
  endtask

  task automatic test_reset_run();
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    btn_mode = 1'b1; tick(); btn_mode = 1'b0;
    btn_run_stop = 1'b1; tick(); btn_run_stop = 1'b0;
    repeat (148) tick();
    n_checks++;
    if (count_bcd !== 8'h37) begin n_errors++; $display("FAIL rr_load got %h exp 37", count_bcd); end
    repeat (2) tick();
    reset = 1'b1; btn_mode = 1'b1; btn_run_stop = 1'b1;
    tick();
    reset = 1'b0; btn_mode = 1'b0; btn_run_stop = 1'b0;
    n_checks++;
    if (count_bcd !== 8'h00 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL rr_count got %h/%b exp 00/0", count_bcd, wrap);
    end
    n_checks++;
    if (led_mode !== 2'b01 || led_run_stop !== 2'b01) begin
      n_errors++;
      $display("FAIL rr_leds got %b/%b exp 01/01", led_mode, led_run_stop);
    end
    // Prescaler must also be back at 0: first step exactly 4 cycles after RUN
    btn_run_stop = 1'b1; tick(); btn_run_stop = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (count_bcd !== 8'h00) begin n_errors++; $display("FAIL rr_presc_early got %h exp 00", count_bcd); end
    tick();
    n_checks++;
    if (count_bcd !== 8'h01) begin n_errors++; $display("FAIL rr_presc_step got %h exp 01", count_bcd); end
  endtask

  initial begin
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_run_stop = 1'b0;
    btn_clear = 1'b0;
    #2;
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_stop_resume();
    test_clear_step();
    test_mode_step();
    test_reset_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
